// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-side front end.
package mips_pkg;

    localparam int XLEN = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_XOR = 6'b100110;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        WAIT  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc4;
    } fetch_pkt_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Single-entry skid register; pairs with the fetch output
// register to form a two-deep elastic stage.
module fetch_skid_buf #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         full;
    logic [W-1:0] data;

    assign in_ready  = !full;
    assign out_valid = full;
    assign out_data  = data;

    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            data <= '0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (in_valid && in_ready) begin
            full <= 1'b1;
            data <= in_data;
        end else if (out_valid && out_ready) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// PC owner and instruction-memory requester feeding decode
// over valid/ready, with redirect squashing of in-flight fetches.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              imem_rvalid,
    input  logic              redirect,
    input  logic [DATA_W-1:0] redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [DATA_W-1:0] id_instr,
    output logic [5:0]        id_opcode,
    output logic [5:0]        id_funct,
    output logic [DATA_W-1:0] id_pc4,
    output logic [15:0]       squash_count
);

    fetch_state_t      state;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] req_pc;
    logic [DATA_W-1:0] target;
    logic              kill;

    logic       issue;
    logic       deliver;
    logic       consume;
    logic       out_free;
    fetch_pkt_t rsp_pkt;

    logic       skid_in_valid;
    logic       skid_in_ready;
    logic       skid_out_valid;
    fetch_pkt_t skid_out_pkt;

    assign target  = {redirect_pc[DATA_W-1:2], 2'b00};
    assign issue   = !rst && (state == FETCH) && !redirect
                   && skid_in_ready;
    assign deliver = (state == WAIT) && imem_rvalid
                   && !kill && !redirect;
    assign consume  = id_valid && id_ready;
    assign out_free = !id_valid || consume;

    assign rsp_pkt.instr = imem_rdata;
    assign rsp_pkt.pc4   = req_pc + 32'd4;

    // Skid only absorbs a word the output register cannot take.
    assign skid_in_valid = deliver
                         && (!out_free || skid_out_valid);

    assign imem_req  = issue;
    assign imem_addr = pc;
    assign id_opcode = id_instr[31:26];
    assign id_funct  = id_instr[5:0];

    fetch_skid_buf #(.W(2 * DATA_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .in_valid  (skid_in_valid),
        .in_ready  (skid_in_ready),
        .in_data   (rsp_pkt),
        .out_valid (skid_out_valid),
        .out_ready (out_free),
        .out_data  (skid_out_pkt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            req_pc       <= '0;
            kill         <= 1'b0;
            squash_count <= '0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (redirect) begin
                        pc <= target;
                    end else if (issue) begin
                        req_pc <= pc;
                        pc     <= pc + 32'd4;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (kill || redirect)
                            squash_count <= sat_inc16(squash_count);
                        if (redirect)
                            pc <= target;
                        kill  <= 1'b0;
                        state <= FETCH;
                    end else if (redirect) begin
                        kill <= 1'b1;
                        pc   <= target;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
            id_pc4   <= '0;
        end else if (redirect) begin
            id_valid <= 1'b0;
        end else if (out_free) begin
            if (skid_out_valid) begin
                id_valid <= 1'b1;
                id_instr <= skid_out_pkt.instr;
                id_pc4   <= skid_out_pkt.pc4;
            end else if (deliver) begin
                id_valid <= 1'b1;
                id_instr <= rsp_pkt.instr;
                id_pc4   <= rsp_pkt.pc4;
            end else begin
                id_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with hand-timed
// memory responses.
module tb_instr_fetch_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [5:0]  id_opcode;
    logic [5:0]  id_funct;
    logic [31:0] id_pc4;
    logic [15:0] squash_count;

    int nchecks = 0;
    int nerrors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_rvalid  (imem_rvalid),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_instr     (id_instr),
        .id_opcode    (id_opcode),
        .id_funct     (id_funct),
        .id_pc4       (id_pc4),
        .squash_count (squash_count)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h",
                     tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        imem_rdata  = '0;
        imem_rvalid = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        id_ready    = 1'b1;
        tick();
        tick();
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'b0, id_valid}, 32'd0);
        rst = 1'b0;
        #1;
        // first post-reset cycle
        chk("c0_req", {31'b0, imem_req}, 32'd1);
        chk("c0_addr", imem_addr, 32'h0);
        chk("c0_instr", id_instr, 32'h0);
        chk("c0_pc4", id_pc4, 32'h0);
        chk("c0_squash", {16'b0, squash_count}, 32'd0);

        // LW with 1-cycle memory
        tick();
        chk("c1_req", {31'b0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h8C22_0004;
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk("lw_valid", {31'b0, id_valid}, 32'd1);
        chk("lw_op", {26'b0, id_opcode}, {26'b0, OP_LW});
        chk("lw_pc4", id_pc4, 32'd4);
        chk("lw_req", {31'b0, imem_req}, 32'd1);
        chk("lw_next", imem_addr, 32'd4);

        // SUB then XOR under backpressure
        tick();
        chk("c3_valid", {31'b0, id_valid}, 32'd0);
        id_ready    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0043_0822;
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk("sub_valid", {31'b0, id_valid}, 32'd1);
        chk("sub_fn", {26'b0, id_funct}, {26'b0, FN_SUB});
        chk("sub_pc4", id_pc4, 32'd8);
        chk("sub_req", {31'b0, imem_req}, 32'd1);
        chk("sub_addr", imem_addr, 32'd8);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0043_0826;
        tick();
        imem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_instr", id_instr, 32'h0043_0822);
            chk("hold_fn", {26'b0, id_funct}, {26'b0, FN_SUB});
            chk("hold_pc4", id_pc4, 32'd8);
            chk("no_3rd_req", {31'b0, imem_req}, 32'd0);
            if (i < 2) tick();
        end
        id_ready = 1'b1;
        tick();
        chk("xor_valid", {31'b0, id_valid}, 32'd1);
        chk("xor_fn", {26'b0, id_funct}, {26'b0, FN_XOR});
        chk("xor_pc4", id_pc4, 32'hC);
        chk("xor_req", {31'b0, imem_req}, 32'd1);
        chk("xor_addr", imem_addr, 32'hC);

        // redirect in WAIT, response three cycles later
        tick();
        chk("c10_valid", {31'b0, id_valid}, 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        #1;
        chk("kill_req", {31'b0, imem_req}, 32'd0);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk("sq_valid", {31'b0, id_valid}, 32'd0);
        chk("sq_count", {16'b0, squash_count}, 32'd1);
        chk("sq_req", {31'b0, imem_req}, 32'd1);
        chk("sq_addr", imem_addr, 32'h100);

        // target word delivered, held for the next test
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h3421_0005;
        id_ready    = 1'b0;
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk("ori_op", {26'b0, id_opcode}, {26'b0, OP_ORI});
        chk("ori_pc4", id_pc4, 32'h104);
        chk("ori_addr", imem_addr, 32'h104);
        tick();
        chk("ori_hold", {31'b0, id_valid}, 32'd1);

        // redirect + rvalid + consume in one cycle
        id_ready    = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1111_1111;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        imem_rvalid = 1'b0;
        redirect    = 1'b0;
        #1;
        chk("rr_valid", {31'b0, id_valid}, 32'd0);
        chk("rr_count", {16'b0, squash_count}, 32'd2);
        chk("rr_req", {31'b0, imem_req}, 32'd1);
        chk("rr_addr", imem_addr, 32'hFFFF_FFFC);

        // PC wrap
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0043_0826;
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk("wrap_instr", id_instr, 32'h0043_0826);
        chk("wrap_pc4", id_pc4, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);

        // reset in WAIT, stray response after it
        tick();
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_0BAD;
        #1;
        chk("prst_req", {31'b0, imem_req}, 32'd1);
        chk("prst_addr", imem_addr, 32'h0);
        chk("prst_valid", {31'b0, id_valid}, 32'd0);
        chk("prst_sq", {16'b0, squash_count}, 32'd0);
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk("stray_valid", {31'b0, id_valid}, 32'd0);
        chk("stray_req", {31'b0, imem_req}, 32'd0);
        tick();
        chk("stray_valid2", {31'b0, id_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 nchecks, nerrors);
        $finish;
    end

endmodule
